valu_issue_wb_sched: RTL

Parametrised successor to the vector ALU front end. It issues operations to NUM_UNITS execution units (VSFX, VCFX, VFPU, and later units), each with its own fixed latency. It tracks every in-flight target register in a reservation table and drives a single shared register-file writeback port with no collisions. It also blocks issue on RAW and WAW hazards and keeps a sticky VSCR SAT bit.

---
 rtl/valu_pkg.sv | 28 ++
 rtl/valu_resv_table.sv | 66 ++++++
 rtl/valu_issue_wb_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU issue/writeback scheduler:
// unit indices, default latencies, and the reservation-table entry type.
package valu_pkg;

  localparam int unsigned VALU_VSFX = 0;
  localparam int unsigned VALU_VCFX = 1;
  localparam int unsigned VALU_VFPU = 2;

  localparam logic [11:0] VALU_UNIT_LAT_DEFAULT = 12'h431;

  // Entry fields are sized for the widest supported configuration
  // (8 units, 8-bit register address); narrower builds use low bits.
  localparam int unsigned VALU_UNIT_W = 3;
  localparam int unsigned VALU_VRT_W  = 8;

  typedef struct packed {
    logic                   valid;
    logic [VALU_UNIT_W-1:0] unit;
    logic [VALU_VRT_W-1:0]  vrt;
  } resv_entry_t;

  function automatic int unsigned lat_of(input logic [63:0] unit_lat,
                                         input int unsigned idx,
                                         input int unsigned lw);
    return 32'((unit_lat >> (idx * lw)) & ~(64'hFFFF_FFFF_FFFF_FFFF << lw));
  endfunction

endpackage

// File: rtl/valu_resv_table.sv
// Reservation shift table: slot 0 is the entry writing back this cycle.
// Provides per-slot valid, RAW and WAW match vectors for issue gating.
module valu_resv_table
  import valu_pkg::*;
#(
  parameter int unsigned LAT_MAX = 8,
  parameter int unsigned RAW     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [LAT_MAX-1:0] push_sel,
  input  resv_entry_t        push_entry,
  input  logic [3*RAW-1:0]   chk_src,
  input  logic [2:0]         chk_src_en,
  input  logic [RAW-1:0]     chk_vrt,
  output logic [LAT_MAX-1:0] slot_valid,
  output logic [LAT_MAX-1:0] raw_match,
  output logic [LAT_MAX-1:0] waw_match,
  output logic [LAT_MAX-1:0] nxt_valid,
  output resv_entry_t        head
);

  resv_entry_t s_q [LAT_MAX];
  resv_entry_t s_d [LAT_MAX];

  always_comb begin
    for (int unsigned k = 0; k < LAT_MAX - 1; k++) begin
      s_d[k] = s_q[k+1];
    end
    s_d[LAT_MAX-1] = '0;
    // The collision check upstream guarantees the target slot's shifted-in
    // occupant is empty, so the push simply overwrites it.
    for (int unsigned k = 0; k < LAT_MAX; k++) begin
      if (push_sel[k]) s_d[k] = push_entry;
    end
    if (flush) begin
      for (int unsigned k = 0; k < LAT_MAX; k++) s_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LAT_MAX; k++) s_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < LAT_MAX; k++) s_q[k] <= s_d[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < LAT_MAX; k++) begin
      slot_valid[k] = s_q[k].valid;
      nxt_valid[k]  = s_d[k].valid;
      waw_match[k]  = s_q[k].valid && (s_q[k].vrt[RAW-1:0] == chk_vrt);
      raw_match[k]  = 1'b0;
      for (int unsigned s = 0; s < 3; s++) begin
        raw_match[k] = raw_match[k] |
                       (s_q[k].valid && chk_src_en[s] &&
                        (s_q[k].vrt[RAW-1:0] == chk_src[s*RAW +: RAW]));
      end
    end
  end

  assign head = s_q[0];

endmodule

// File: rtl/valu_issue_wb_sched.sv
// Vector ALU issue front end: gates issue on slot collision and RAW/WAW
// hazards, drives the shared writeback port, and keeps sticky VSCR SAT.
module valu_issue_wb_sched
  import valu_pkg::*;
#(
  parameter int unsigned             NUM_UNITS = 3,
  parameter int unsigned             LW        = 4,
  parameter logic [NUM_UNITS*LW-1:0] UNIT_LAT  = VALU_UNIT_LAT_DEFAULT,
  parameter int unsigned             LAT_MAX   = 8,
  parameter int unsigned             RAW       = 5,
  localparam int unsigned            UW        = $clog2(NUM_UNITS),
  localparam int unsigned            CW        = $clog2(LAT_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [UW-1:0]        in_unit,
  input  logic [RAW-1:0]       in_vrt,
  input  logic [3*RAW-1:0]     in_src,
  input  logic [2:0]           in_src_en,
  output logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_sat,
  input  logic                 flush,
  input  logic                 vscr_clr,
  output logic                 wb_en,
  output logic [UW-1:0]        wb_unit,
  output logic [RAW-1:0]       wb_vrt,
  output logic                 vscr_sat,
  output logic [CW-1:0]        inflight_cnt,
  output logic                 err_bad_unit
);

  if (NUM_UNITS < 2 || NUM_UNITS > 8) begin : g_bad_num_units
    $error("valu_issue_wb_sched: NUM_UNITS must be 2..8");
  end
  if (RAW > VALU_VRT_W) begin : g_bad_raw
    $error("valu_issue_wb_sched: RAW exceeds entry vrt width");
  end
  if (NUM_UNITS * LW > 64) begin : g_bad_lat_width
    $error("valu_issue_wb_sched: UNIT_LAT wider than 64 bits");
  end
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_lat_chk
    if (lat_of(64'(UNIT_LAT), u, LW) < 1 ||
        lat_of(64'(UNIT_LAT), u, LW) > LAT_MAX) begin : g_bad_lat
      $error("valu_issue_wb_sched: unit latency outside 1..LAT_MAX");
    end
  end

  logic [LAT_MAX-1:0] slot_valid, raw_match, waw_match, nxt_valid;
  logic [LAT_MAX-1:0] lat_sel, push_sel;
  resv_entry_t        push_entry, head;
  logic               unit_ok, collide, hazard, accept, sat_hit;
  int unsigned        lat;
  logic [CW-1:0]      cnt_d, cnt_q;
  logic               vscr_sat_q, err_q;
  logic               unused_head;

  valu_resv_table #(
    .LAT_MAX (LAT_MAX),
    .RAW     (RAW)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_sel   (push_sel),
    .push_entry (push_entry),
    .chk_src    (in_src),
    .chk_src_en (in_src_en),
    .chk_vrt    (in_vrt),
    .slot_valid (slot_valid),
    .raw_match  (raw_match),
    .waw_match  (waw_match),
    .nxt_valid  (nxt_valid),
    .head       (head)
  );

  always_comb begin
    unit_ok = (32'(in_unit) < NUM_UNITS);
    lat     = 1;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (32'(in_unit) == u) lat = lat_of(64'(UNIT_LAT), u, LW);
    end
    for (int unsigned k = 0; k < LAT_MAX; k++) begin
      lat_sel[k] = unit_ok && (lat == k + 1);
    end
    // The slot just above the target must be free, otherwise both entries
    // would land in the same writeback cycle.
    collide = 1'b0;
    for (int unsigned k = 0; k < LAT_MAX - 1; k++) begin
      collide = collide | (lat_sel[k] & slot_valid[k+1]);
    end
    hazard   = (|raw_match) || (|waw_match);
    in_ready = unit_ok && !collide && !hazard && !flush;
    accept   = in_valid && in_ready;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      unit_start[u] = accept && (32'(in_unit) == u);
    end
    push_sel         = accept ? lat_sel : '0;
    push_entry.valid = 1'b1;
    push_entry.unit  = VALU_UNIT_W'(in_unit);
    push_entry.vrt   = VALU_VRT_W'(in_vrt);
  end

  always_comb begin
    sat_hit = 1'b0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (head.valid && unit_sat[u] && (head.unit == VALU_UNIT_W'(u))) sat_hit = 1'b1;
    end
    cnt_d = '0;
    for (int unsigned k = 0; k < LAT_MAX; k++) begin
      cnt_d = cnt_d + CW'(nxt_valid[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vscr_sat_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (sat_hit) begin
        vscr_sat_q <= 1'b1;
      end else if (vscr_clr) begin
        vscr_sat_q <= 1'b0;
      end
      cnt_q <= cnt_d;
      err_q <= in_valid && !unit_ok;
    end
  end

  assign wb_en        = head.valid;
  assign wb_unit      = head.unit[UW-1:0];
  assign wb_vrt       = head.vrt[RAW-1:0];
  assign vscr_sat     = vscr_sat_q;
  assign inflight_cnt = cnt_q;
  assign err_bad_unit = err_q;
  assign unused_head  = ^head;

endmodule
